cir_resp_checker: RTL and testbench
===================================

Name: cir_resp_checker

Overview:
Sequential response checker for the 4-input gate cluster `cir`. It sits at the output end of the exhaustive stimulus path and consumes (vector, observed output) beats over a valid/ready handshake. Each beat is scored against a golden model. The block counts passes and fails, latches the first failing vector, flags out-of-order vectors, and compacts the response stream into a MISR signature. A self-checking bench or a BIST wrapper reads the result once `done` is high.

Parameters:
NUM_VEC, 16, number of beats per run
CNT_W, 5, width of the pass/fail counters; must hold NUM_VEC
SIG_W, 8, MISR width; must be at least 5
SIG_POLY, 8'h1D, MISR feedback taps

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; clears results and begins a run
in_valid  input  1  beat present
in_vec  input  4  applied vector {a,b,c,d}, with a as the MSB
in_o  input  1  observed `cir` output for in_vec
in_ready  output  1  checker accepts a beat
busy  output  1  run in progress
done  output  1  run complete; held until the next start
pass_cnt  output  CNT_W  beats matching golden
fail_cnt  output  CNT_W  beats mismatching golden
first_fail_vld  output  1  at least one fail this run
first_fail_vec  output  4  in_vec of the first fail
err_seq  output  1  sticky; some in_vec differed from the expected index
signature  output  SIG_W  MISR state

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. All registers update on the rising edge of clk.
- Reset values: state=IDLE; all counters, the signature, first_fail_vec and exp_idx are 0; every flag is 0.
- Golden function: exp_o = (a&b) ^ ~(c|d).
- FSM states:
  - IDLE: start -> RUN.
  - RUN: the beat that makes the accepted count reach NUM_VEC -> DONE. start -> RUN (restart with results cleared).
  - DONE: start -> RUN. Otherwise hold.
- On start: clear pass_cnt, fail_cnt, first_fail_*, err_seq, signature and exp_idx. The run begins on the next cycle.
- in_ready = (state==RUN) & ~start. It is combinational. No beats are accepted in IDLE or DONE.
- If start and in_valid are high together, start wins and the beat is dropped.
- A beat is accepted when in_valid & in_ready. All result updates land on that clock edge, so results are visible one cycle after acceptance.
- Scoring per accepted beat:
  - in_o==exp_o(in_vec): pass_cnt+1.
  - Otherwise: fail_cnt+1. If first_fail_vld==0, latch in_vec into first_fail_vec and set first_fail_vld.
- Sequence check: if in_vec != exp_idx[3:0], set err_seq (sticky). The beat is still scored against in_vec. exp_idx increments on every accepted beat.
- MISR update per accepted beat: sig <= (sig<<1) ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ zero-extended {in_vec,in_o}.
- Counters cannot exceed NUM_VEC because acceptance stops in DONE, so no saturation logic is needed.
- busy = (state==RUN). done = (state==DONE). Both are registered state decodes.
- Gaps: in_valid low for any number of cycles stalls the run. No state changes during a gap.
- Reset mid-run: returns to IDLE immediately and asynchronously. All results are lost.
- Outputs remain stable in DONE until the next start.

Decomposition:
- Shared package `cir_pkg` holds:
  - VEC_W=4
  - the state enum {IDLE, RUN, DONE}
  - default SIG_POLY and SIG_W
  - a golden function cir_exp(vec) for bench reuse.
- One combinational sub-module, `cir_golden` (4-bit vec in, exp_o out), instantiated once. The bench uses it or cir_exp as its scoreboard.

Test Plan:
- Clean sweep: start, then i=0..15 with in_o=exp_o, back-to-back. Expected in_o is 1 for i=0,4,8,13,14,15 and 0 otherwise. Required: done one cycle after beat 15, pass_cnt=16, fail_cnt=0, first_fail_vld=0, err_seq=0, signature equal to the bench MISR model.
- Fault injection: same sweep but in_o=1 at i=5 and in_o=0 at i=13. Required: fail_cnt=2, pass_cnt=14, first_fail_vec=4'd5, and a signature differing from the clean run.
- Ordering and stalls: send 0,1,3,2,4..15 with random 0-3 cycle in_valid gaps. Required: err_seq=1, fail_cnt=0, done only after the 16th accepted beat, and no count change during gaps.
- Handshake edges: in_valid high in IDLE, then start asserted together with in_valid, then in_valid high in DONE. Required: in_ready=0 in all three cases, and all three beats are ignored (counts unchanged).
- Restart and reset: start again after 7 beats, then run 16 clean beats. Required: pass_cnt=16, not 23. Then assert rst asynchronously mid-run, between clock edges. Required: outputs read 0, state IDLE and in_ready=0 before the next clk edge.

Source files
------------

// File: rtl/cir_pkg.sv
// Shared types and constants for the cir gate-cluster checker: vector width,
// checker FSM states, default MISR configuration and the golden function.
package cir_pkg;

  localparam int         VEC_W        = 4;
  localparam int         SIG_W_DEF    = 8;
  localparam logic [7:0] SIG_POLY_DEF = 8'h1D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // vec = {a,b,c,d}, a is the MSB.
  function automatic logic cir_exp(input logic [VEC_W-1:0] vec);
    return (vec[3] & vec[2]) ^ ~(vec[1] | vec[0]);
  endfunction

endpackage

// File: rtl/cir_golden.sv
// Combinational golden model of the cir gate cluster.
module cir_golden
  import cir_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             exp_o
);

  assign exp_o = cir_exp(vec);

endmodule

// File: rtl/cir_resp_checker.sv
// Scores (vector, observed output) beats against the cir golden model, counts
// pass/fail, latches the first failure, checks ordering and builds a MISR.
module cir_resp_checker
  import cir_pkg::*;
#(
  parameter int               NUM_VEC  = 16,
  parameter int               CNT_W    = 5,
  parameter int               SIG_W    = SIG_W_DEF,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [VEC_W-1:0] in_vec,
  input  logic             in_o,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             err_seq,
  output logic [SIG_W-1:0] signature
);

  state_t           state_q, state_d;
  logic             accept;
  logic             last_beat;
  logic             exp_o;
  logic [CNT_W-1:0] exp_idx;
  logic [SIG_W-1:0] sig_next;

  cir_golden u_golden (
    .vec   (in_vec),
    .exp_o (exp_o)
  );

  // start takes priority: a beat presented together with start is dropped.
  assign in_ready  = (state_q == RUN) & ~start;
  assign accept    = in_valid & in_ready;
  assign last_beat = (exp_idx == CNT_W'(NUM_VEC - 1));

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  assign sig_next = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? SIG_POLY : '0)
                  ^ {{(SIG_W-VEC_W-1){1'b0}}, in_vec, in_o};

  // NOTE: every path assigns state_d by taking the default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = RUN;
               else if (accept && last_beat) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      err_seq        <= 1'b0;
      signature      <= '0;
      exp_idx        <= '0;
    end else if (start) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      err_seq        <= 1'b0;
      signature      <= '0;
      exp_idx        <= '0;
    end else if (accept) begin
      if (in_o == exp_o) begin
        pass_cnt <= pass_cnt + 1'b1;
      end else begin
        fail_cnt <= fail_cnt + 1'b1;
        if (!first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_vec <= in_vec;
        end
      end
      // Out-of-order vectors are still scored against the vector actually sent.
      if (in_vec != exp_idx[VEC_W-1:0]) err_seq <= 1'b1;
      signature <= sig_next;
      exp_idx   <= exp_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_cir_resp_checker.sv
// Self-checking bench for cir_resp_checker: table-driven beat runs with a
// scoreboard of expected result snapshots, plus handshake/restart/reset cases.
module tb_cir_resp_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [3:0] in_vec;
  logic       in_o;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [4:0] pass_cnt;
  logic [4:0] fail_cnt;
  logic       first_fail_vld;
  logic [3:0] first_fail_vec;
  logic       err_seq;
  logic [7:0] signature;

  cir_resp_checker dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_vec         (in_vec),
    .in_o           (in_o),
    .in_ready       (in_ready),
    .busy           (busy),
    .done           (done),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_vld (first_fail_vld),
    .first_fail_vec (first_fail_vec),
    .err_seq        (err_seq),
    .signature      (signature)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vec;
    logic       o;
    int         gap;
    logic       exp_pass;
  } beat_t;

  typedef struct {
    logic [4:0] pass;
    logic [4:0] fail;
    logic       ffv;
    logic [3:0] ffvec;
    logic       err;
    logic [7:0] sig;
    logic       busy;
    logic       done;
  } snap_t;

  // cir output for vectors 0..15: ones at 0,4,8,13,14,15.
  logic [15:0] gold = 16'hE111;

  beat_t tbl[16];
  snap_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [4:0] m_pass, m_fail;
  logic       m_ffv, m_err, m_busy, m_done;
  logic [3:0] m_ffvec;
  logic [7:0] m_sig;
  int         m_idx;
  logic [7:0] sig_clean;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_pass = '0; m_fail = '0; m_ffv = 1'b0; m_ffvec = '0;
    m_err = 1'b0; m_sig = '0; m_idx = 0;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.pass = m_pass; s.fail = m_fail; s.ffv = m_ffv; s.ffvec = m_ffvec;
    s.err = m_err; s.sig = m_sig; s.busy = m_busy; s.done = m_done;
    return s;
  endfunction

  task automatic compare_pop();
    snap_t s;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    s = sb.pop_front();
    check("pass_cnt", pass_cnt, s.pass);
    check("fail_cnt", fail_cnt, s.fail);
    check("first_fail_vld", first_fail_vld, s.ffv);
    check("first_fail_vec", first_fail_vec, s.ffvec);
    check("err_seq", err_seq, s.err);
    check("signature", signature, s.sig);
    check("busy", busy, s.busy);
    check("done", done, s.done);
  endtask

  // Entered and left on a falling edge; in_valid stays high for back-to-back beats.
  task automatic send_beat(input beat_t b);
    repeat (b.gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("gap_pass_cnt", pass_cnt, m_pass);
      check("gap_fail_cnt", fail_cnt, m_fail);
    end
    in_valid = 1'b1;
    in_vec   = b.vec;
    in_o     = b.o;
    #1 check("in_ready", in_ready, m_busy);
    @(posedge clk);
    if (m_busy) begin
      if (b.exp_pass) m_pass = m_pass + 1'b1;
      else begin
        m_fail = m_fail + 1'b1;
        if (!m_ffv) begin m_ffv = 1'b1; m_ffvec = b.vec; end
      end
      if (b.vec != m_idx[3:0]) m_err = 1'b1;
      m_sig = {m_sig[6:0], 1'b0} ^ (m_sig[7] ? 8'h1D : 8'h00) ^ {3'b000, b.vec, b.o};
      m_idx++;
      if (m_idx == 16) begin m_busy = 1'b0; m_done = 1'b1; end
    end
    sb.push_back(model_snap());
    @(negedge clk);
    compare_pop();
  endtask

  task automatic pulse_start(input logic with_valid);
    start    = 1'b1;
    in_valid = with_valid;
    in_vec   = 4'hA;
    in_o     = 1'b1;
    #1 check("in_ready_during_start", in_ready, 1'b0);
    @(posedge clk);
    model_clear();
    m_busy = 1'b1;
    m_done = 1'b0;
    sb.push_back(model_snap());
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    compare_pop();
  endtask

  task automatic fill_clean();
    for (int i = 0; i < 16; i++) begin
      tbl[i].vec = 4'(i);
      tbl[i].o   = gold[i];
      tbl[i].gap = 0;
    end
  endtask

  task automatic fix_exp();
    for (int i = 0; i < 16; i++) tbl[i].exp_pass = (tbl[i].o == gold[tbl[i].vec]);
  endtask

  task automatic run_table(input int n);
    for (int i = 0; i < n; i++) send_beat(tbl[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_vec = '0; in_o = 1'b0;
    model_clear();
    m_busy = 1'b0; m_done = 1'b0;
    repeat (2) @(negedge clk);
    sb.push_back(model_snap());
    compare_pop();
    check("reset_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Beat offered in IDLE is ignored.
    fill_clean(); fix_exp();
    send_beat(tbl[0]);

    // Start together with a beat: beat dropped, then a clean sweep.
    pulse_start(1'b1);
    run_table(16);
    check("clean_done", done, 1'b1);
    check("clean_pass", pass_cnt, 5'd16);
    check("clean_fail", fail_cnt, 5'd0);
    check("clean_ffv", first_fail_vld, 1'b0);
    check("clean_err", err_seq, 1'b0);
    sig_clean = m_sig;

    // Beat offered in DONE is ignored.
    send_beat(tbl[3]);

    // Fault injection.
    pulse_start(1'b0);
    fill_clean();
    tbl[5].o  = 1'b1;
    tbl[13].o = 1'b0;
    fix_exp();
    run_table(16);
    check("fault_fail", fail_cnt, 5'd2);
    check("fault_pass", pass_cnt, 5'd14);
    check("fault_ffvec", first_fail_vec, 4'd5);
    check("fault_sig_differs", signature != sig_clean, 1'b1);

    // Out-of-order vectors with random stalls.
    fill_clean();
    tbl[2].vec = 4'd3; tbl[2].o = gold[3];
    tbl[3].vec = 4'd2; tbl[3].o = gold[2];
    for (int i = 0; i < 16; i++) tbl[i].gap = int'($urandom_range(3, 0));
    fix_exp();
    pulse_start(1'b0);
    run_table(16);
    check("order_err", err_seq, 1'b1);
    check("order_fail", fail_cnt, 5'd0);
    check("order_done", done, 1'b1);

    // Restart after 7 beats, then a full clean run.
    fill_clean(); fix_exp();
    pulse_start(1'b0);
    run_table(7);
    pulse_start(1'b0);
    run_table(16);
    check("restart_pass", pass_cnt, 5'd16);

    // Asynchronous reset between clock edges mid-run.
    pulse_start(1'b0);
    run_table(5);
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_pass", pass_cnt, 5'd0);
    check("arst_fail", fail_cnt, 5'd0);
    check("arst_sig", signature, 8'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
